// File: rtl/anim_seq_pkg.sv
// Shared state encoding, frame-index constants and the resume helper for the
// animation sequencer.
package anim_seq_pkg;

    typedef logic [2:0]  state_t;
    typedef logic [11:0] frame_t;

    // FSM state encoding (also driven out on the state port)
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RUN  = 3'd1;
    localparam state_t ST_JUMP = 3'd2;
    localparam state_t ST_DUCK = 3'd3;
    localparam state_t ST_DEAD = 3'd4;

    // Frame index map: 1..640 run loop, 642..645 jump, 646..649 duck, 650 dead
    localparam frame_t RUN_LEN     = 12'd640;
    localparam frame_t HALF_IDX    = 12'd128;
    localparam frame_t JUMP_BASE   = 12'd642;
    localparam frame_t DOWN_BASE   = 12'd646;
    localparam frame_t ACT_LEN     = 12'd4;
    localparam frame_t DEAD_IDX    = 12'd650;
    localparam frame_t RESUME_SKIP = 12'd4;

    localparam frame_t JUMP_LAST   = JUMP_BASE + ACT_LEN - 12'd1;
    localparam frame_t DOWN_LAST   = DOWN_BASE + ACT_LEN - 12'd1;

    // Run frame to resume at after an action: skip ahead, folding past the
    // end of the run loop back to its start (never lands on 0 or 641).
    function automatic frame_t resume_idx(input frame_t saved);
        frame_t sum;
        sum = saved + RESUME_SKIP;
        if (sum > RUN_LEN) begin
            return sum - RUN_LEN;
        end
        return sum;
    endfunction

endpackage

// File: rtl/anim_seq_ctrl_if.sv
// Player-input / sprite-output bundle of the animation sequencer.
interface anim_seq_ctrl_if;

    logic        slow_clk;
    logic        kp_jump;
    logic        kp_down;
    logic        dead;
    logic [11:0] frame_idx;
    logic [2:0]  state;
    logic        action_done;
    logic        run_wrap;

    // Stimulus side: drives frame clock and key/collision levels
    modport master (
        output slow_clk, kp_jump, kp_down, dead,
        input  frame_idx, state, action_done, run_wrap
    );

    // Sequencer side
    modport slave (
        input  slow_clk, kp_jump, kp_down, dead,
        output frame_idx, state, action_done, run_wrap
    );

endinterface

// File: rtl/anim_seq_ctrl_tick_sync.sv
// Brings the asynchronous frame-rate square wave into the clk domain and
// produces a one-clk tick per rising edge. An edge only counts once two
// genuine post-reset samples exist, so a wave already high at reset release
// does not fire a tick.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_tick
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       r_prev_vld;

    // Two-flop synchronizer plus history flop and sample-validity tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_fill     <= 2'b00;
            r_prev_vld <= 1'b0;
        end else begin
            r_sync1    <= i_async;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_fill     <= {r_fill[0], 1'b1};
            r_prev_vld <= r_fill[1];
        end
    end

    assign o_tick = r_prev_vld & r_sync2 & ~r_prev;

endmodule

// File: rtl/anim_seq_ctrl.sv
// Sprite/note index sequencer: runs a 640-frame loop with a one-shot intro
// replay, inserts 4-frame jump/duck actions that resume slightly ahead, and
// parks on a death frame while the collision flag is held.
module anim_seq_ctrl (
    input  logic            clk,
    input  logic            rst,
    anim_seq_ctrl_if.slave  bus
);
    import anim_seq_pkg::*;

    logic   w_tick;
    state_t r_state;
    frame_t r_frame;
    frame_t r_saved;
    logic   r_intro;
    logic   r_done;
    logic   r_wrap;

    state_t w_state_nxt;
    frame_t w_frame_nxt;
    frame_t w_saved_nxt;
    logic   w_intro_nxt;
    logic   w_done_nxt;
    logic   w_wrap_nxt;

    tick_sync u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.slow_clk),
        .o_tick  (w_tick)
    );

    // Next-state decision for one frame tick: dead > jump > duck > advance
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_saved_nxt = r_saved;
        w_intro_nxt = r_intro;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (bus.dead) begin
            w_state_nxt = ST_DEAD;
            w_frame_nxt = DEAD_IDX;
            w_saved_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_frame_nxt = 12'd1;
                end
                ST_RUN: begin
                    if (bus.kp_jump) begin
                        w_saved_nxt = r_frame;
                        w_state_nxt = ST_JUMP;
                        w_frame_nxt = JUMP_BASE;
                    end else if (bus.kp_down) begin
                        w_saved_nxt = r_frame;
                        w_state_nxt = ST_DUCK;
                        w_frame_nxt = DOWN_BASE;
                    end else if (r_frame == HALF_IDX) begin
                        // First pass through the intro replays it once
                        if (!r_intro) begin
                            w_frame_nxt = 12'd1;
                            w_intro_nxt = 1'b1;
                        end else begin
                            w_frame_nxt = HALF_IDX + 12'd1;
                        end
                    end else if (r_frame >= RUN_LEN) begin
                        w_frame_nxt = 12'd1;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_frame_nxt = r_frame + 12'd1;
                    end
                end
                ST_JUMP: begin
                    if (r_frame >= JUMP_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_frame_nxt = resume_idx(r_saved);
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_frame_nxt = r_frame + 12'd1;
                    end
                end
                ST_DUCK: begin
                    if (r_frame >= DOWN_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_frame_nxt = resume_idx(r_saved);
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_frame_nxt = r_frame + 12'd1;
                    end
                end
                ST_DEAD: begin
                    w_state_nxt = ST_RUN;
                    w_frame_nxt = 12'd1;
                    w_intro_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_frame_nxt = '0;
                    w_saved_nxt = '0;
                    w_intro_nxt = 1'b0;
                end
            endcase
        end
    end

    // State registers advance only on tick; event pulses last one clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_frame <= '0;
            r_saved <= '0;
            r_intro <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= w_tick & w_done_nxt;
            r_wrap <= w_tick & w_wrap_nxt;
            if (w_tick) begin
                r_state <= w_state_nxt;
                r_frame <= w_frame_nxt;
                r_saved <= w_saved_nxt;
                r_intro <= w_intro_nxt;
            end
        end
    end

    assign bus.frame_idx   = r_frame;
    assign bus.state       = r_state;
    assign bus.action_done = r_done;
    assign bus.run_wrap    = r_wrap;

endmodule

// File: tb/tb_anim_seq_ctrl.sv
// Directed bench for anim_seq_ctrl: walks the run loop, intro replay, wrap,
// jump/duck actions, death and reset scenarios with hand-computed indices.
module tb_anim_seq_ctrl;
    import anim_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   n_wrap  = 0;
    int   n_both  = 0;
    int   n_step  = 0;

    anim_seq_ctrl_if u_if ();

    anim_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (u_if.action_done) n_done++;
        if (u_if.run_wrap) n_wrap++;
        if (u_if.action_done && u_if.run_wrap) n_both++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s step %0d: observed %0d expected %0d", tag, n_step, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One frame-clock period; checks index, state and pulse counts for it
    task automatic step(input int ef, input int es, input int ed, input int ew);
        int d0;
        int w0;
        d0 = n_done;
        w0 = n_wrap;
        n_step++;
        @(negedge clk);
        u_if.slow_clk = 1'b1;
        repeat (6) @(negedge clk);
        u_if.slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        chk("frame", int'(u_if.frame_idx), ef);
        chk("state", int'(u_if.state), es);
        chk("done",  n_done - d0, ed);
        chk("wrap",  n_wrap - w0, ew);
    endtask

    initial begin
        u_if.slow_clk = 1'b1;
        u_if.kp_jump  = 1'b0;
        u_if.kp_down  = 1'b0;
        u_if.dead     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame", int'(u_if.frame_idx), 0);
        chk("rst_state", int'(u_if.state), int'(ST_IDLE));
        chk("rst_pulse", int'(u_if.action_done) + int'(u_if.run_wrap), 0);

        // Release with the frame clock already high: no tick may fire
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("nohigh_frame", int'(u_if.frame_idx), 0);
        chk("nohigh_state", int'(u_if.state), int'(ST_IDLE));
        u_if.slow_clk = 1'b0;
        repeat (4) @(negedge clk);

        // First tick, intro run, intro replay, then to the wrap
        step(1, ST_RUN, 0, 0);
        for (int e = 2; e <= 128; e++) step(e, ST_RUN, 0, 0);
        step(1, ST_RUN, 0, 0);
        for (int e = 2; e <= 128; e++) step(e, ST_RUN, 0, 0);
        step(129, ST_RUN, 0, 0);
        for (int e = 130; e <= 640; e++) step(e, ST_RUN, 0, 0);
        step(1, ST_RUN, 0, 1);

        // Jump at 300 resumes at 304
        for (int e = 2; e <= 300; e++) step(e, ST_RUN, 0, 0);
        u_if.kp_jump = 1'b1;
        step(642, ST_JUMP, 0, 0);
        u_if.kp_jump = 1'b0;
        step(643, ST_JUMP, 0, 0);
        step(644, ST_JUMP, 0, 0);
        step(645, ST_JUMP, 0, 0);
        step(304, ST_RUN, 1, 0);

        // Duck at 638 resumes at 2; jump held through the duck is ignored
        for (int e = 305; e <= 638; e++) step(e, ST_RUN, 0, 0);
        u_if.kp_down = 1'b1;
        step(646, ST_DUCK, 0, 0);
        u_if.kp_down = 1'b0;
        u_if.kp_jump = 1'b1;
        step(647, ST_DUCK, 0, 0);
        step(648, ST_DUCK, 0, 0);
        step(649, ST_DUCK, 0, 0);
        step(2, ST_RUN, 1, 0);

        // Death during a jump, held, then restart with intro cleared
        step(642, ST_JUMP, 0, 0);
        u_if.kp_jump = 1'b0;
        step(643, ST_JUMP, 0, 0);
        u_if.dead = 1'b1;
        step(650, ST_DEAD, 0, 0);
        for (int k = 0; k < 5; k++) step(650, ST_DEAD, 0, 0);
        u_if.dead = 1'b0;
        step(1, ST_RUN, 0, 0);
        for (int e = 2; e <= 128; e++) step(e, ST_RUN, 0, 0);
        step(1, ST_RUN, 0, 0);

        // Reset in the middle of a jump takes effect without a clock edge
        u_if.kp_jump = 1'b1;
        step(642, ST_JUMP, 0, 0);
        u_if.kp_jump = 1'b0;
        step(643, ST_JUMP, 0, 0);
        step(644, ST_JUMP, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_frame", int'(u_if.frame_idx), 0);
        chk("async_state", int'(u_if.state), int'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        step(1, ST_RUN, 0, 0);

        // Death straight out of idle
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        u_if.dead = 1'b1;
        repeat (2) @(negedge clk);
        step(650, ST_DEAD, 0, 0);
        u_if.dead = 1'b0;
        step(1, ST_RUN, 0, 0);

        chk("pulse_excl", n_both, 0);
        chk("total_wrap", n_wrap, 1);
        chk("total_done", n_done, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_seq_ctrl.md
ANIM_SEQ_CTRL -- requirements
Module: anim_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port slow_clk, input, 1, frame-rate square wave, asynchronous to clk.
REQ-004 SHALL have port kp_jump, input, 1, jump request, level-sampled.
REQ-005 SHALL have port kp_down, input, 1, duck request, level-sampled.
REQ-006 SHALL have port dead, input, 1, collision/death flag, level-sampled.
REQ-007 SHALL have port frame_idx, output, 12, registered sprite/note index.
REQ-008 SHALL have port state, output, 3, registered current FSM state encoding.
REQ-009 SHALL have port action_done, output, 1, one-clk pulse on JUMP/DUCK return to RUN.
REQ-010 SHALL have port run_wrap, output, 1, one-clk pulse on RUN wrap 640->1.

Function
REQ-011 SHALL derive internal tick: 2-FF synchronize slow_clk, tick = one-clk pulse per synchronized rising edge.
REQ-012 SHALL sample kp_jump, kp_down, dead and update frame_idx/state only in tick cycles; frame_idx changes on the clk edge after tick.
REQ-013 SHALL implement states IDLE=0, RUN=1, JUMP=2, DUCK=3, DEAD=4.
REQ-014 SHALL apply per-tick priority: dead > kp_jump > kp_down > normal advance.
REQ-015 IDLE: on tick (dead=0) -> RUN, frame_idx=1; dead=1 -> DEAD, 650.
REQ-016 RUN advance: frame_idx+1; at 128 with intro=0 -> 1 and set intro; at 128 with intro=1 -> 129; at 640 -> 1 with run_wrap pulse.
REQ-017 RUN + kp_jump: save frame_idx, -> JUMP, frame_idx=642; RUN + kp_down: save, -> DUCK, 646.
REQ-018 JUMP steps 642..645, DUCK steps 646..649, one per tick; kp_jump/kp_down ignored in both.
REQ-019 From 645 or 649: -> RUN, frame_idx=saved+4, minus 640 if result >640; action_done pulse.
REQ-020 dead=1 on tick in IDLE/RUN/JUMP/DUCK -> DEAD, frame_idx=650, saved value discarded.
REQ-021 DEAD: hold 650 while dead=1; tick with dead=0 -> RUN, frame_idx=1, intro cleared.
REQ-022 frame_idx SHALL never take 641 or values >650.
REQ-023 action_done and run_wrap SHALL be mutually exclusive and high exactly one clk.

Reset
REQ-024 rst=1 SHALL immediately force frame_idx=0, state=IDLE, intro=0, saved=0, pulses=0, sync flops=0.
REQ-025 Reset mid-JUMP/DUCK/DEAD SHALL abandon the action; first tick after release -> RUN, frame_idx=1.
REQ-026 First synchronized slow_clk edge after release SHALL only fire tick if slow_clk was sampled low then high.

Structure
REQ-027 Package anim_seq_pkg SHALL hold state encoding and constants RUN_LEN=640, HALF_IDX=128, JUMP_BASE=642, DOWN_BASE=646, ACT_LEN=4, DEAD_IDX=650, RESUME_SKIP=4.
REQ-028 Sub-module tick_sync SHALL implement the synchronizer/edge detector of REQ-011; FSM, save register and flags stay in anim_seq_ctrl.

Verification
REQ-029 Reset, 1 slow_clk edge -> tick, frame_idx 0->1, state RUN.
REQ-030 Run 128 ticks -> 128; next tick -> 1, intro set; run to 128 -> 129; at 640 next tick -> 1 with run_wrap pulse.
REQ-031 kp_jump at frame 300 -> 642,643,644,645, then 304 in RUN, action_done one clk.
REQ-032 kp_down at frame 638 -> 646..649, then 2 (642 wrapped); kp_jump held during DUCK has no effect.
REQ-033 dead=1 at frame 643 -> 650 DEAD, held 5 ticks; dead=0 -> 1 RUN, intro=0 (next 128 wraps to 1).
REQ-034 rst pulse mid-JUMP (frame 644) -> frame_idx 0, IDLE same cycle; next tick -> 1.
